// File: rtl/popcount_sched.sv
`default_nettype none
// ============================================================================
// Module   : popcount_sched
// Purpose  : Shared round-robin population-count engine. One requester at a
//            time is granted, its vector is counted CHUNK bits per cycle, and
//            the result is returned together with the requester index.
// Options  : ZERO_SKIP_EN - finish counting early once the remaining shifted
//            bits are all zero (same result, shorter latency).
// Revision : 1.0 - initial release
// ============================================================================
module popcount_sched #(
    parameter int NUM_REQ  = 4,
    parameter int IN_WIDTH = 16,
    parameter int CHUNK    = 4
) (
    input  wire logic                              clk,
    input  wire logic                              rst_n,
    input  wire logic [NUM_REQ-1:0]                req_valid,
    output logic      [NUM_REQ-1:0]                req_ready,
    input  wire logic [NUM_REQ*IN_WIDTH-1:0]       req_data,
    output logic                                   rsp_valid,
    input  wire logic                              rsp_ready,
    output logic      [$clog2(IN_WIDTH):0]         rsp_count,
    output logic      [$clog2(NUM_REQ)-1:0]        rsp_id
);

    localparam int K  = IN_WIDTH / CHUNK;
    localparam int CW = $clog2(IN_WIDTH) + 1;
    localparam int IW = $clog2(NUM_REQ);
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_id;
    logic [IN_WIDTH-1:0] r_shift;
    logic [CW-1:0]       r_acc;
    logic [KW-1:0]       r_cnt;

    logic                w_found;
    logic [IW-1:0]       w_gidx;
    logic [IW-1:0]       w_cand;
    logic                w_accept;
    logic                w_last;
    logic [CW-1:0]       w_chunk_pc;
    logic [IN_WIDTH-1:0] w_shift_next;
    logic [IN_WIDTH-1:0] w_sel_data;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = IW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    // Grant only while idle and out of reset, so ready is zero during reset.
    assign req_ready  = (r_state == S_IDLE && rst_n && w_found) ?
                        (NUM_REQ'(1) << w_gidx) : '0;
    assign w_accept   = (r_state == S_IDLE) && w_found;
    assign w_sel_data = req_data[w_gidx*IN_WIDTH +: IN_WIDTH];

    // Ones in the lowest chunk of the shift register.
    always_comb begin
        w_chunk_pc = '0;
        for (int j = 0; j < CHUNK; j++) begin
            w_chunk_pc = w_chunk_pc + CW'(r_shift[j]);
        end
    end

    assign w_shift_next = r_shift >> CHUNK;

`ifdef ZERO_SKIP_EN
    assign w_last = (r_cnt == KW'(K-1)) || (w_shift_next == '0);
`else
    assign w_last = (r_cnt == KW'(K-1));
`endif

    assign rsp_valid = (r_state == S_DONE);
    assign rsp_count = r_acc;
    assign rsp_id    = r_id;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a response accept always returns to IDLE for one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_next = S_COUNT;
            S_COUNT: if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture on grant, accumulate one chunk per COUNT cycle, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_shift <= w_sel_data;
                r_acc   <= '0;
                r_id    <= w_gidx;
                r_cnt   <= '0;
                r_ptr   <= (w_gidx == IW'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
            end else if (r_state == S_COUNT) begin
                r_acc   <= r_acc + w_chunk_pc;
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_popcount_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcount_sched
// Purpose  : Directed self-checking bench for popcount_sched.
// Options  : ZERO_SKIP_EN changes the expected latencies in test_zero_skip.
// Revision : 1.0 - initial release
// ============================================================================
module tb_popcount_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_count;
    logic [1:0]  rsp_id;

    int total;
    int bad;

`ifdef ZERO_SKIP_EN
    localparam int LAT_LOW  = 1;
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_LOW  = 4;
    localparam int LAT_ZERO = 4;
`endif

    popcount_sched #(.NUM_REQ(4), .IN_WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_count (rsp_count),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges until rsp_valid is seen, capped at 50.
    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Edges until some req_ready bit is seen, capped at 50.
    task automatic wait_grant(output int n);
        n = 0;
        while (req_ready === 4'b0000 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0)   begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_count !== 5'd0)   begin bad++; $display("FAIL reset_rsp_count got=%0d exp=0", rsp_count); end
        total++; if (rsp_id !== 2'd0)      begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        total++; if (req_ready !== 4'b0)   begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int n;
        do_reset();
        req_data  = {16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(n);
        total++; if (n != 4)              begin bad++; $display("FAIL single_latency got=%0d exp=4", n); end
        total++; if (rsp_count !== 5'd16) begin bad++; $display("FAIL single_count got=%0d exp=16", rsp_count); end
        total++; if (rsp_id !== 2'd1)     begin bad++; $display("FAIL single_id got=%0d exp=1", rsp_id); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0)  begin bad++; $display("FAIL single_drop got=%b exp=0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int n;
        int exp_cnt [5] = '{2, 4, 0, 8, 2};
        logic [3:0] exp_rdy;
        do_reset();
        req_data  = {16'hAAAA, 16'h0000, 16'h00F0, 16'h8001};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            wait_grant(n);
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, req_ready, exp_rdy); end
            @(posedge clk); #1;
            wait_rsp(n);
            total++; if (rsp_id !== 2'(k % 4)) begin bad++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, rsp_id, k % 4); end
            total++; if (int'(rsp_count) != exp_cnt[k]) begin bad++; $display("FAIL rr_count[%0d] got=%0d exp=%0d", k, rsp_count, exp_cnt[k]); end
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        req_data  = {16'h0000, 16'h0000, 16'h0000, 16'h1234};
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        wait_rsp(n);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (rsp_valid !== 1'b1)   begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, rsp_valid); end
            total++; if (rsp_count !== 5'd5)   begin bad++; $display("FAIL bp_count[%0d] got=%0d exp=5", c, rsp_count); end
            total++; if (rsp_id !== 2'd0)      begin bad++; $display("FAIL bp_id[%0d] got=%0d exp=0", c, rsp_id); end
            total++; if (req_ready !== 4'b0)   begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL bp_same_cycle_grant got=%b exp=0000", req_ready); end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0)    begin bad++; $display("FAIL bp_drop got=%b exp=0", rsp_valid); end
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next_grant got=%b exp=0010", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        req_data  = {16'h0000, 16'hFFFF, 16'h0000, 16'h0003};
        req_valid = 4'b0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", rsp_valid); end
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL areset_ready got=%b exp=0000", req_ready); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL areset_first_grant got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(n);
        total++; if (n != 4)             begin bad++; $display("FAIL areset_latency got=%0d exp=4", n); end
        total++; if (rsp_id !== 2'd0)    begin bad++; $display("FAIL areset_id got=%0d exp=0", rsp_id); end
        total++; if (rsp_count !== 5'd2) begin bad++; $display("FAIL areset_count got=%0d exp=2", rsp_count); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_zero_skip();
        int n;
        logic [15:0] vec  [3] = '{16'h000F, 16'hF000, 16'h0000};
        int          lat  [3] = '{LAT_LOW, 4, LAT_ZERO};
        int          cnt  [3] = '{4, 4, 0};
        do_reset();
        for (int t = 0; t < 3; t++) begin
            req_data  = {48'h0, vec[t]};
            req_valid = 4'b0001;
            #1;
            @(posedge clk); #1;
            req_valid = '0;
            wait_rsp(n);
            total++; if (n != lat[t]) begin bad++; $display("FAIL zs_latency[%0d] got=%0d exp=%0d", t, n, lat[t]); end
            total++; if (int'(rsp_count) != cnt[t]) begin bad++; $display("FAIL zs_count[%0d] got=%0d exp=%0d", t, rsp_count, cnt[t]); end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        test_zero_skip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
